// File: rtl/ram_queue_ctrl.sv
// ram_queue_ctrl
// FIFO queue controller that keeps its entries in an external RAM.
// The RAM has a synchronous write port and an asynchronous read port.
// Entries occupy RAM addresses BASE_ADDR .. BASE_ADDR+RAM_DEPTH-1.
//
// Optional feature (define the macro to enable it):
//   RAM_QUEUE_BYPASS_EN - an enqueue into an empty queue while the consumer
//                         is ready passes straight through to o_deq_data in
//                         the same cycle. There is no RAM write, and the
//                         pointers and count do not change.
// The default build leaves the macro undefined. In that build an entry
// always passes through the RAM, and it appears at the dequeue side one
// cycle after it is written.

module ram_queue_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int RAM_DEPTH  = 8,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          i_flush,

    input  logic                          i_enq_valid,
    output logic                          o_enq_ready,
    input  logic [DATA_WIDTH-1:0]         i_enq_data,

    output logic                          o_deq_valid,
    input  logic                          i_deq_ready,
    output logic [DATA_WIDTH-1:0]         o_deq_data,

    output logic [$clog2(RAM_DEPTH):0]    o_count,

    output logic                          o_ram_wr_en,
    output logic [ADDR_WIDTH-1:0]         o_ram_wr_addr,
    output logic [DATA_WIDTH-1:0]         o_ram_data_in,

    output logic                          o_ram_rd_en,
    output logic [ADDR_WIDTH-1:0]         o_ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]         i_ram_data_out
);

    // Pointers carry one extra wrap bit above the RAM index. This bit tells
    // "full" apart from "empty" when both indices are equal.
    localparam int IDX_W = $clog2(RAM_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR_C = ADDR_WIDTH'(BASE_ADDR);

    logic [PTR_W-1:0] headPtr_q, headPtr_d;
    logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
    logic [PTR_W-1:0] count_q,   count_d;

    logic             queueEmpty;
    logic             queueFull;
    logic             enqFire;
    logic             deqFire;
    logic             bypassFire;
    logic [IDX_W-1:0] headIdx;
    logic [IDX_W-1:0] tailIdx;

    assign headIdx = headPtr_q[IDX_W-1:0];
    assign tailIdx = tailPtr_q[IDX_W-1:0];

    // Empty means the pointers are identical. Full means the indices match
    // but the pointers are one lap apart.
    assign queueEmpty = (headPtr_q == tailPtr_q);
    assign queueFull  = (headIdx == tailIdx) &&
                        (headPtr_q[PTR_W-1] != tailPtr_q[PTR_W-1]);

    // A pass-through applies only when nothing is stored yet and the
    // consumer takes the word immediately. A flush always takes priority.
`ifdef RAM_QUEUE_BYPASS_EN
    assign bypassFire = i_enq_valid && queueEmpty && i_deq_ready && !i_flush;
`else
    assign bypassFire = 1'b0;
`endif

    // Ready depends only on fullness. A dequeue in the same cycle never
    // makes room early, which keeps o_enq_ready free of combinational
    // paths from the consumer.
    assign o_enq_ready = !queueFull;

    // During a flush, both handshakes are ignored, and so is a pass-through,
    // which would otherwise hide the word from the RAM.
    assign enqFire = i_enq_valid && !queueFull && !i_flush && !bypassFire;
    assign deqFire = !queueEmpty && i_deq_ready && !i_flush;

    // Write port. The address always stays inside the entry window because
    // only the index bits are added to the base.
    assign o_ram_wr_en   = enqFire;
    assign o_ram_wr_addr = BASE_ADDR_C + ADDR_WIDTH'(tailIdx);
    assign o_ram_data_in = i_enq_data;

    // The read port continuously looks at the head entry. The RAM reads
    // asynchronously, so the head word is visible in the same cycle.
    assign o_ram_rd_en   = !queueEmpty;
    assign o_ram_rd_addr = BASE_ADDR_C + ADDR_WIDTH'(headIdx);

    // The dequeue side shows the head entry, or the incoming word when it
    // is passing straight through.
    assign o_deq_valid = !queueEmpty || bypassFire;
    assign o_deq_data  = bypassFire ? i_enq_data : i_ram_data_out;

    assign o_count = count_q;

    // Next-state pointer and occupancy logic. A flush clears everything.
    // Otherwise each pointer moves independently, and the count follows
    // the net change.
    always_comb begin
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        count_d   = count_q;
        if (i_flush) begin
            headPtr_d = '0;
            tailPtr_d = '0;
            count_d   = '0;
        end else begin
            if (enqFire) begin
                tailPtr_d = tailPtr_q + PTR_W'(1);
            end
            if (deqFire) begin
                headPtr_d = headPtr_q + PTR_W'(1);
            end
            case ({enqFire, deqFire})
                2'b10:   count_d = count_q + PTR_W'(1);
                2'b01:   count_d = count_q - PTR_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers. Reset drops all queued entries but leaves the RAM
    // untouched. The stale words are never read back, because the queue
    // restarts empty.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
        end else begin
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_ram_queue_ctrl.sv
// tb_ram_queue_ctrl
// This bench drives ram_queue_ctrl (RAM_DEPTH=4, BASE_ADDR=16) against a
// behavioural RAM. It compares every cycle with a queue-based reference
// model of the FIFO rules. The expectations follow RAM_QUEUE_BYPASS_EN
// when that macro is defined.

module tb_ram_queue_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int BASE  = 16;
    localparam int AW    = 8;
`ifdef RAM_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk;
    logic          n_rst;
    logic          flush;
    logic          enqValid;
    logic          enqReady;
    logic [DW-1:0] enqData;
    logic          deqValid;
    logic          deqReady;
    logic [DW-1:0] deqData;
    logic [2:0]    count;
    logic          ramWrEn;
    logic [AW-1:0] ramWrAddr;
    logic [DW-1:0] ramDataIn;
    logic          ramRdEn;
    logic [AW-1:0] ramRdAddr;
    logic [DW-1:0] ramDataOut;

    logic [DW-1:0] ramMem [0:255];

    int testCount = 0;
    int failCount = 0;

    // Reference model: the stored words in order, plus the RAM slot where
    // the head and tail currently sit.
    int modelQ[$];
    int modelHead = 0;
    int modelTail = 0;

    ram_queue_ctrl #(
        .DATA_WIDTH (DW),
        .RAM_DEPTH  (DEPTH),
        .BASE_ADDR  (BASE),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .i_flush        (flush),
        .i_enq_valid    (enqValid),
        .o_enq_ready    (enqReady),
        .i_enq_data     (enqData),
        .o_deq_valid    (deqValid),
        .i_deq_ready    (deqReady),
        .o_deq_data     (deqData),
        .o_count        (count),
        .o_ram_wr_en    (ramWrEn),
        .o_ram_wr_addr  (ramWrAddr),
        .o_ram_data_in  (ramDataIn),
        .o_ram_rd_en    (ramRdEn),
        .o_ram_rd_addr  (ramRdAddr),
        .i_ram_data_out (ramDataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (ramWrEn) ramMem[ramWrAddr] <= ramDataIn;
    end
    assign ramDataOut = ramMem[ramRdAddr];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        modelQ.delete();
        modelHead = 0;
        modelTail = 0;
    endtask

    // Drive one cycle of inputs and check all outputs against the model
    // before the edge. Then let the edge happen and advance the model.
    task automatic applyStimulus(input bit ev, input int data, input bit dr, input bit fl);
        bit isEmpty, isFull, byp, enqOk, deqOk;
        enqValid = ev;
        enqData  = DW'(data);
        deqReady = dr;
        flush    = fl;
        #1;
        isEmpty = (modelQ.size() == 0);
        isFull  = (modelQ.size() == DEPTH);
        byp     = BYPASS && ev && isEmpty && dr && !fl;
        enqOk   = ev && !isFull && !fl && !byp;
        deqOk   = !isEmpty && dr && !fl;

        checkOutput("count",    32'(count),    32'(modelQ.size()));
        checkOutput("enqReady", 32'(enqReady), 32'(!isFull));
        checkOutput("deqValid", 32'(deqValid), 32'(!isEmpty || byp));
        checkOutput("rdEn",     32'(ramRdEn),  32'(!isEmpty));
        checkOutput("wrEn",     32'(ramWrEn),  32'(enqOk));
        if (enqOk) begin
            checkOutput("wrAddr", 32'(ramWrAddr), 32'(BASE + modelTail));
            checkOutput("wrData", 32'(ramDataIn), 32'(data & 8'hFF));
        end
        if (byp) begin
            checkOutput("bypassData", 32'(deqData), 32'(data & 8'hFF));
        end else if (!isEmpty) begin
            checkOutput("rdAddr",  32'(ramRdAddr), 32'(BASE + modelHead));
            checkOutput("deqData", 32'(deqData),   32'(modelQ[0]));
        end

        @(posedge clk);
        #1;
        if (fl) begin
            modelClear();
        end else begin
            if (deqOk) begin
                void'(modelQ.pop_front());
                modelHead = (modelHead + 1) % DEPTH;
            end
            if (enqOk) begin
                modelQ.push_back(data & 8'hFF);
                modelTail = (modelTail + 1) % DEPTH;
            end
        end
    endtask

    initial begin
        n_rst    = 1'b0;
        flush    = 1'b0;
        enqValid = 1'b0;
        enqData  = '0;
        deqReady = 1'b0;
        for (int i = 0; i < 256; i++) ramMem[i] = '0;

        // Outputs while reset is held.
        #2;
        checkOutput("rstCount",    32'(count),    32'd0);
        checkOutput("rstDeqValid", 32'(deqValid), 32'd0);
        checkOutput("rstEnqReady", 32'(enqReady), 32'd1);
        checkOutput("rstWrEn",     32'(ramWrEn),  32'd0);
        checkOutput("rstRdEn",     32'(ramRdEn),  32'd0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full, then drain in order.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'hA0 + i, 1'b0, 1'b0);
        #1;
        checkOutput("fullEnqReady", 32'(enqReady), 32'd0);
        checkOutput("fullCount",    32'(count),    32'd4);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("drainOrder", 32'(deqData), 32'(8'hA0 + i));
            applyStimulus(1'b0, 0, 1'b1, 1'b0);
        end

        // Wrap: restart from slot 0, then interleave 6 enqueues and 4 dequeues.
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        applyStimulus(1'b0, 0,     1'b1, 1'b0);
        applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h13, 1'b0, 1'b0);
        applyStimulus(1'b0, 0,     1'b1, 1'b0);
        #1;
        checkOutput("wrap5thAddr", 32'(ramWrAddr), 32'(BASE));
        applyStimulus(1'b1, 8'h14, 1'b0, 1'b0);
        applyStimulus(1'b0, 0,     1'b1, 1'b0);
        applyStimulus(1'b1, 8'h15, 1'b0, 1'b0);
        applyStimulus(1'b0, 0,     1'b1, 1'b0);
        #1;
        checkOutput("wrapCount", 32'(count),   32'd2);
        checkOutput("wrapHead",  32'(deqData), 32'h14);

        // Full with enqueue and dequeue both offered: only the dequeue happens.
        applyStimulus(1'b1, 8'h16, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h17, 1'b0, 1'b0);
        #1;
        checkOutput("fullBothWrEn", 32'(ramWrEn), 32'd0);
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
        checkOutput("fullBothCount", 32'(count), 32'd3);

        // Flush at count 2 with an enqueue offered.
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("preFlushCount", 32'(count), 32'd2);
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b1);
        checkOutput("flushCount",    32'(count),    32'd0);
        checkOutput("flushDeqValid", 32'(deqValid), 32'd0);

        // Enqueue into an empty queue with the consumer ready.
        if (BYPASS) begin
            applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
            checkOutput("bypassCount", 32'(count), 32'd0);
        end else begin
            #1;
            checkOutput("emptyWrAddr", 32'(ramWrAddr), 32'(BASE));
            applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
            checkOutput("latDeqValid", 32'(deqValid), 32'd1);
            checkOutput("latDeqData",  32'(deqData),  32'h5A);
            applyStimulus(1'b0, 0, 1'b1, 1'b0);
        end

        // Reset mid-traffic at count 3 takes effect without a clock edge.
        applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h32, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
        checkOutput("preRstCount", 32'(count), 32'd3);
        enqValid = 1'b1;
        n_rst    = 1'b0;
        #1;
        checkOutput("midRstCount",    32'(count),    32'd0);
        checkOutput("midRstDeqValid", 32'(deqValid), 32'd0);
        checkOutput("midRstEnqReady", 32'(enqReady), 32'd1);
        enqValid = 1'b0;
        modelClear();
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 6), int'($urandom_range(0, 255)),
                          ($urandom_range(0, 1) == 1), ($urandom_range(0, 39) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/ram_queue_ctrl.md
RAM_QUEUE_CTRL -- requirements
Module: ram_queue_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, queue entry width in bits.
REQ-002 SHALL have parameter RAM_DEPTH, default 8, number of entries; power of two, >=2.
REQ-003 SHALL have parameter BASE_ADDR, default 0, RAM address of entry 0.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8, RAM address bus width.
REQ-005 SHALL have: clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have: n_rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have: i_flush  input  1  synchronous queue clear.
REQ-008 SHALL have: i_enq_valid  input  1; o_enq_ready  output  1; i_enq_data  input  DATA_WIDTH  (enqueue handshake).
REQ-009 SHALL have: o_deq_valid  output  1; i_deq_ready  input  1; o_deq_data  output  DATA_WIDTH  (dequeue handshake).
REQ-010 SHALL have: o_count  output  $clog2(RAM_DEPTH)+1  current occupancy.
REQ-011 SHALL have: o_ram_wr_en  output  1; o_ram_wr_addr  output  ADDR_WIDTH; o_ram_data_in  output  DATA_WIDTH  (synchronous RAM write port).
REQ-012 SHALL have: o_ram_rd_en  output  1; o_ram_rd_addr  output  ADDR_WIDTH; i_ram_data_out  input  DATA_WIDTH  (asynchronous RAM read port, data valid same cycle).

Function
REQ-013 SHALL hold head and tail pointers of $clog2(RAM_DEPTH)+1 bits; index = low $clog2(RAM_DEPTH) bits; empty when equal; full when indices equal and MSBs differ.
REQ-014 SHALL assert o_enq_ready = !full, independent of dequeue activity.
REQ-015 SHALL treat an enqueue as occurring when i_enq_valid && o_enq_ready at a rising edge.
REQ-016 SHALL drive o_ram_wr_en = enqueue, o_ram_wr_addr = BASE_ADDR + tail index, o_ram_data_in = i_enq_data combinationally in the same cycle.
REQ-017 SHALL drive o_ram_rd_en = !empty, o_ram_rd_addr = BASE_ADDR + head index, o_deq_data = i_ram_data_out combinationally.
REQ-018 SHALL assert o_deq_valid = !empty; dequeue occurs when o_deq_valid && i_deq_ready at a rising edge.
REQ-019 SHALL increment tail (mod 2*RAM_DEPTH) on enqueue and head on dequeue; wrap from index RAM_DEPTH-1 to 0.
REQ-020 SHALL keep o_count unchanged on simultaneous enqueue and dequeue, +1 on enqueue only, -1 on dequeue only.
REQ-021 SHALL give enqueue-to-dequeue latency of one cycle: an entry written into an empty queue is presented on o_deq_valid the following cycle.
REQ-022 SHALL, when full, refuse enqueue even if a dequeue occurs the same cycle.
REQ-023 SHALL, on i_flush, reset head, tail and o_count to 0 at the edge, suppress o_ram_wr_en that cycle, and ignore enqueue/dequeue.
REQ-024 SHALL leave i_enq_data unsampled when o_enq_ready is low; never write a RAM address outside BASE_ADDR..BASE_ADDR+RAM_DEPTH-1.

Reset
REQ-025 SHALL, while n_rst is low, asynchronously clear head, tail and count, giving o_deq_valid=0, o_enq_ready=1, o_count=0, o_ram_wr_en=0, o_ram_rd_en=0.
REQ-026 SHALL discard all queued entries on reset mid-operation; RAM contents are not cleared and not re-read.

Configuration
REQ-027 SHALL support macro RAM_QUEUE_BYPASS_EN; when defined, an enqueue into an empty queue with i_deq_ready high presents i_enq_data on o_deq_data with o_deq_valid=1 that same cycle, no RAM write, pointers and count unchanged.
REQ-028 SHALL, without RAM_QUEUE_BYPASS_EN, never assert o_deq_valid while empty (latency per REQ-021).

Verification
REQ-029 SHALL test reset: n_rst low mid-traffic with count=3 -> o_count=0, o_deq_valid=0, o_enq_ready=1 immediately, no edge needed.
REQ-030 SHALL test fill/drain, DEPTH=4, BASE_ADDR=16: enqueue 0xA0..0xA3 -> write addrs 16,17,18,19, o_enq_ready=0 at count=4; drain yields 0xA0..0xA3 in order.
REQ-031 SHALL test wrap: 6 enqueues interleaved with 4 dequeues -> 5th write to addr 16, o_count=2, order preserved.
REQ-032 SHALL test full with simultaneous valid/ready: count=4, i_enq_valid=1, i_deq_ready=1 -> dequeue only, o_count=3, no RAM write.
REQ-033 SHALL test flush: count=2, i_flush with i_enq_valid=1 -> o_count=0, o_ram_wr_en=0, o_deq_valid=0 next cycle.
REQ-034 SHALL test empty enqueue 0x5A with i_deq_ready=1 -> with RAM_QUEUE_BYPASS_EN: o_deq_data=0x5A same cycle, count stays 0; without: write addr BASE_ADDR, o_deq_valid next cycle.
